// File: rtl/pkt_rr_arb_ctrl_pkg.sv
// rtl/pkt_rr_arb_ctrl_pkg.sv - shared types and helpers for the packet round-robin arbiter
package pkt_rr_arb_ctrl_pkg;

  // Controller state: IDLE arbitrates every cycle, LOCKED holds one port until its tail.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Rotate a width-n vector left by one; bit n-1 wraps to bit 0. Carried at 64 bits
  // so one function serves any port count; callers cast the result back to width.
  function automatic logic [63:0] rotl1(input logic [63:0] v, input int unsigned n);
    logic [63:0] mask;
    mask  = (64'd1 << n) - 64'd1;
    rotl1 = ((v << 1) | (v >> (n - 1))) & mask;
  endfunction

  // Stall counter width, wide enough to hold STALL_MAX.
  function automatic int stall_cnt_w(input int stall_max);
    stall_cnt_w = $clog2(stall_max + 1);
  endfunction

endpackage

// File: rtl/pkt_rr_arb_ctrl_fixed_arbiter_base.sv
// rtl/pkt_rr_arb_ctrl_fixed_arbiter_base.sv - fixed-priority arbiter with rotating base and single-port override
module fixed_arbiter_base #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] request,
  input  logic [NUM_REQ-1:0] base,
  input  logic               arb_enable,
  input  logic [NUM_REQ-1:0] single_mask,
  output logic [NUM_REQ-1:0] grant
);

  logic [2*NUM_REQ-1:0] double_req;
  logic [2*NUM_REQ-1:0] double_grant;

  // Circular priority search: subtracting the one-hot base from the doubled request
  // vector clears everything below the first requester at or after base.
  always_comb begin
    double_req   = {request, request};
    double_grant = double_req & ~(double_req - {{NUM_REQ{1'b0}}, base});
    if (arb_enable) begin
      grant = double_grant[NUM_REQ-1:0] | double_grant[2*NUM_REQ-1:NUM_REQ];
    end else begin
      grant = single_mask & request;
    end
  end

endmodule

// File: rtl/pkt_rr_arb_ctrl.sv
// rtl/pkt_rr_arb_ctrl.sv - packet-level round-robin arbitration controller for one output port
module pkt_rr_arb_ctrl
  import pkt_rr_arb_ctrl_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int STALL_MAX = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] request,
  input  logic [NUM_REQ-1:0] req_tail,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic               xfer,
  output logic               locked,
  output logic [NUM_REQ-1:0] base_q,
  output logic               stall_err
);

  localparam int CW = stall_cnt_w(STALL_MAX);

  state_t             state;
  logic [NUM_REQ-1:0] lock_mask;
  logic [CW-1:0]      stall_cnt;
  logic               arb_enable;
  logic               tail_hit;
  logic [NUM_REQ-1:0] grant_rot;
  logic [NUM_REQ-1:0] lock_rot;

  assign arb_enable = (state == IDLE);

  fixed_arbiter_base #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .request     (request),
    .base        (base_q),
    .arb_enable  (arb_enable),
    .single_mask (lock_mask),
    .grant       (grant)
  );

  assign grant_valid = |grant;
  assign xfer        = grant_valid & out_ready;
  assign tail_hit    = |(grant & req_tail);
  assign locked      = (state == LOCKED);
  assign grant_rot   = NUM_REQ'(rotl1(64'(grant), NUM_REQ));
  assign lock_rot    = NUM_REQ'(rotl1(64'(lock_mask), NUM_REQ));

  // Packet lock FSM, round-robin pointer update and lock stall watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base_q    <= NUM_REQ'(1);
      lock_mask <= '0;
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else begin
      stall_err <= 1'b0;
      case (state)
        IDLE: begin
          stall_cnt <= '0;
          if (xfer) begin
            if (tail_hit) begin
              base_q <= grant_rot;
            end else begin
              state     <= LOCKED;
              lock_mask <= grant;
            end
          end
        end
        LOCKED: begin
          if (xfer) begin
            stall_cnt <= '0;
            if (tail_hit) begin
              state     <= IDLE;
              base_q    <= lock_rot;
              lock_mask <= '0;
            end
          end else if (stall_cnt == CW'(STALL_MAX - 1)) begin
            // Report the stall but keep the lock so the packet stays intact.
            stall_err <= 1'b1;
            stall_cnt <= '0;
          end else begin
            stall_cnt <= stall_cnt + CW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          lock_mask <= '0;
          stall_cnt <= '0;
        end
      endcase
    end
  end

endmodule
